// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (2-flop synchronized input, mid-bit sampling) feeding a circular byte FIFO.
// Handshake: a byte transfers on every clk edge where rx_valid & rx_ready; rx_data holds while rx_valid & !rx_ready.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 174,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ser_rx,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  clr_err,
    output logic [2:0]            state_dbg
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = 12;
    localparam logic [CW-1:0]       HALF_BIT = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]       FULL_BIT = CW'(CLK_DIV);
    localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_q, state_n;
    logic            rx_meta, rxs, rxs_d;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [2:0]      idx_q, idx_n;
    logic [7:0]      shreg_q, shreg_n;
    logic            push, ferr_n, expire;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  pop, full, wr_en;

    // rxs_d keeps the previous synchronized level for start-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shreg_q <= shreg_n;
        end
    end

    // A load of N expires on the Nth cycle after the load.
    assign expire = (cnt_q == CW'(1));

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shreg_n = shreg_q;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_n = START;
                    cnt_n   = HALF_BIT;
                end
            end
            START: begin
                if (expire) begin
                    if (!rxs) begin
                        state_n = DATA;
                        cnt_n   = FULL_BIT;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_n[idx_q] = rxs;
                    cnt_n          = FULL_BIT;
                    if (idx_q == 3'd7) state_n = STOP;
                    else               idx_n   = idx_q + 3'd1;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (expire) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            BREAK: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign state_dbg = state_q;
    assign rx_valid  = (rx_count != '0);
    assign rx_data   = rx_valid ? mem[rd_ptr] : 8'h00;
    assign pop       = rx_valid & rx_ready;
    assign full      = (rx_count == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en     = push & (!full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_n;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            if (push && full && !pop) overrun <= 1'b1;
            else if (clr_err)         overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLK_DIV=16, DEPTH_LOG2=3; expectations are hand-derived constants.
module tb_uart_rx_fifo;
    localparam int DIV = 16;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic       clk, reset, ser_rx, rx_ready, clr_err;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [3:0] rx_count;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int ferr_cycles = 0;
    int f0;
    logic v154, v155;
    logic       s_valid, s_ferr, s_ovr;
    logic [7:0] s_data;
    logic [3:0] s_count;
    logic [2:0] s_state;

    uart_rx_fifo #(.CLK_DIV(DIV), .DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun),
        .clr_err(clr_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) ferr_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 160-cycle frame starting at a negedge. Stop sample lands on the edge after c=154.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at, input int rst_at);
        for (int c = 0; c < 10 * DIV; c++) begin
            @(negedge clk);
            if (c == 154) v154 = rx_valid;
            if (c == 155) v155 = rx_valid;
            if (c < DIV)            ser_rx = 1'b0;
            else if (c < 9 * DIV) begin
                int b;
                b = (c - DIV) / DIV;
                ser_rx = d[b[2:0]];
            end else                ser_rx = stop;
            if (pop_at >= 0) rx_ready = (c == pop_at);
            if (c == rst_at) reset = 1'b1;
            if (c == rst_at + 2) begin
                s_valid = rx_valid; s_data = rx_data; s_count = rx_count;
                s_ferr = frame_err; s_ovr = overrun; s_state = state_dbg;
            end
            if (c == rst_at + 3) reset = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b1, -1, -1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, rx_valid, 1'b1);
        chk({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ser_rx = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_count", rx_count, 4'd0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_state", state_dbg, ST_IDLE);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // single byte, push latency
        send_frame(8'hA5, 1'b1, -1, -1);
        chk("a5_lat_before", v154, 1'b0);
        chk("a5_lat_after", v155, 1'b1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_count", rx_count, 4'd1);
        chk("a5_ferr", ferr_cycles, 0);
        chk("a5_ovr", overrun, 1'b0);
        repeat (5) @(negedge clk);
        chk("a5_hold", rx_data, 8'hA5);
        pop_exp("a5_pop", 8'hA5);
        chk("a5_empty_valid", rx_valid, 1'b0);
        chk("a5_empty_data", rx_data, 8'h00);
        chk("a5_empty_count", rx_count, 4'd0);

        // fill, overrun, drain in order
        for (int i = 0; i < 8; i++) send(8'(i));
        chk("full_count", rx_count, 4'd8);
        chk("full_ovr", overrun, 1'b0);
        send(8'h08);
        chk("ovr_count", rx_count, 4'd8);
        chk("ovr_set", overrun, 1'b1);
        for (int i = 0; i < 8; i++) pop_exp($sformatf("ovr_pop%0d", i), 8'(i));
        chk("ovr_drain_valid", rx_valid, 1'b0);
        chk("ovr_drain_count", rx_count, 4'd0);
        chk("ovr_sticky", overrun, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr_clr", overrun, 1'b0);

        // full FIFO, pop coinciding with stop sample
        for (int i = 0; i < 8; i++) send(8'(i));
        send_frame(8'h08, 1'b1, 154, -1);
        repeat (3) @(negedge clk);
        chk("pp_count", rx_count, 4'd8);
        chk("pp_ovr", overrun, 1'b0);
        for (int i = 1; i < 9; i++) pop_exp($sformatf("pp_pop%0d", i), 8'(i));
        chk("pp_drain_count", rx_count, 4'd0);

        // framing error followed by break
        f0 = ferr_cycles;
        send_frame(8'h3C, 1'b0, -1, -1);
        chk("fe_pulse", ferr_cycles - f0, 1);
        chk("fe_break", state_dbg, ST_BREAK);
        repeat (40) @(negedge clk);
        chk("fe_dropped", rx_count, 4'd0);
        ser_rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("fe_idle", state_dbg, ST_IDLE);
        send(8'h11);
        chk("fe_pulse_once", ferr_cycles - f0, 1);
        chk("fe_count", rx_count, 4'd1);
        pop_exp("fe_pop", 8'h11);
        chk("fe_empty", rx_count, 4'd0);

        // short low glitch on an idle line
        f0 = ferr_cycles;
        ser_rx = 1'b0;
        repeat (5) @(negedge clk);
        ser_rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("gl_state", state_dbg, ST_IDLE);
        chk("gl_count", rx_count, 4'd0);
        chk("gl_ferr", ferr_cycles - f0, 0);
        send(8'hC3);
        pop_exp("gl_pop", 8'hC3);

        // reset mid-byte with a stale byte held
        send(8'h77);
        chk("rm_pre_count", rx_count, 4'd1);
        send_frame(8'hFF, 1'b1, -1, 84);
        chk("rm_valid", s_valid, 1'b0);
        chk("rm_data", s_data, 8'h00);
        chk("rm_count", s_count, 4'd0);
        chk("rm_ferr", s_ferr, 1'b0);
        chk("rm_ovr", s_ovr, 1'b0);
        chk("rm_state", s_state, ST_IDLE);
        chk("rm_after_count", rx_count, 4'd0);
        chk("rm_after_valid", rx_valid, 1'b0);
        repeat (4) @(negedge clk);
        send(8'h5A);
        chk("rm_5a_count", rx_count, 4'd1);
        pop_exp("rm_5a_pop", 8'h5A);
        chk("rm_5a_empty", rx_count, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
